// File: rtl/conv_loop_controller.sv
// -----------------------------------------------------------------------------
// conv_loop_controller
//
// Loop sequencer for one convolution layer. After start it walks the six loop
// indices (outermost to innermost: j, k, i, m, n, l), issuing one
// multiply-accumulate term per cycle to addr_generator. It flags
// out-of-image taps through pad_zero and strobes en_save once each output
// pixel's accumulation has travelled through the MAC pipeline.
//
// Ports
//   clk       in   1  clock, all state on rising edge
//   reset     in   1  asynchronous, active-low reset
//   start     in   1  begin a layer; only sampled in IDLE
//   stall     in   1  freeze the index walk this cycle (back-pressure)
//   enable    out  1  indices valid this cycle (addr_generator.enable)
//   en_save   out  1  one-cycle strobe: output pixel accumulation complete
//   i,j,k     out  8  output channel, output row, output column
//   m,n       out  8  kernel row, kernel column
//   l         out  8  input channel
//   pad_zero  out  1  registered; one cycle after the enable it refers to
//   busy      out  1  high from the cycle after start is accepted until done
//   done      out  1  one-cycle pulse at layer end
// -----------------------------------------------------------------------------
module conv_loop_controller #(
    parameter int CONV_DIM_IMG    = 32,
    parameter int CONV_DIM_KERNEL = 5,
    parameter int CONV_DIM_CH     = 3,
    parameter int CONV_OUT_CH     = 32,
    parameter int CONV_DIM_OUT    = 32,
    parameter int STRIDE          = 1,
    parameter int PADDING         = 2,
    parameter int SAVE_LAT        = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stall,
    output logic       enable,
    output logic       en_save,
    output logic [7:0] i,
    output logic [7:0] j,
    output logic [7:0] k,
    output logic [7:0] m,
    output logic [7:0] n,
    output logic [7:0] l,
    output logic       pad_zero,
    output logic       busy,
    output logic       done
);

    localparam logic [7:0] L_MAX = 8'(CONV_DIM_CH - 1);
    localparam logic [7:0] N_MAX = 8'(CONV_DIM_KERNEL - 1);
    localparam logic [7:0] M_MAX = 8'(CONV_DIM_KERNEL - 1);
    localparam logic [7:0] I_MAX = 8'(CONV_OUT_CH - 1);
    localparam logic [7:0] K_MAX = 8'(CONV_DIM_OUT - 1);
    localparam logic [7:0] J_MAX = 8'(CONV_DIM_OUT - 1);

    // Drain counter only needs to reach SAVE_LAT-1.
    localparam int DW = (SAVE_LAT > 1) ? $clog2(SAVE_LAT) : 1;
    localparam logic [DW-1:0] DRAIN_LAST = DW'(SAVE_LAT - 1);

    localparam logic signed [9:0] IMG_S = 10'(CONV_DIM_IMG);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state, state_next;

    logic [DW-1:0]       drain_cnt;
    logic [SAVE_LAT-1:0] save_dly;

    logic       pixel_last;
    logic       last_term;
    logic       push;
    logic [7:0] i_nx, j_nx, k_nx, m_nx, n_nx, l_nx;

    logic signed [9:0] row;
    logic signed [9:0] col;
    logic              out_of_image;

    assign pixel_last = (m == M_MAX) && (n == N_MAX) && (l == L_MAX);
    assign last_term  = pixel_last && (i == I_MAX) && (j == J_MAX) && (k == K_MAX);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and enable
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        enable     = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = RUN;
            end
            RUN: begin
                enable = ~stall;
                if (!stall && last_term) state_next = DRAIN;
            end
            DRAIN: begin
                // Last en_save leaves the delay line in the final DRAIN cycle.
                if (drain_cnt == DRAIN_LAST) state_next = DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state == RUN) || (state == DRAIN);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drain_cnt <= '0;
        end else if (state == DRAIN) begin
            drain_cnt <= drain_cnt + 1'b1;
        end else begin
            drain_cnt <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Index walk: l fastest, carries ripple l -> n -> m -> i -> k -> j
    // ------------------------------------------------------------------
    always_comb begin
        i_nx = i;
        j_nx = j;
        k_nx = k;
        m_nx = m;
        n_nx = n;
        l_nx = l + 8'd1;
        if (l == L_MAX) begin
            l_nx = 8'd0;
            n_nx = n + 8'd1;
            if (n == N_MAX) begin
                n_nx = 8'd0;
                m_nx = m + 8'd1;
                if (m == M_MAX) begin
                    m_nx = 8'd0;
                    i_nx = i + 8'd1;
                    if (i == I_MAX) begin
                        i_nx = 8'd0;
                        k_nx = k + 8'd1;
                        if (k == K_MAX) begin
                            k_nx = 8'd0;
                            j_nx = j + 8'd1;
                        end
                    end
                end
            end
        end
    end

    // The final term does not advance, so the indices rest at their maxima
    // until the next start reloads them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            i <= '0;
            j <= '0;
            k <= '0;
            m <= '0;
            n <= '0;
            l <= '0;
        end else if (state == IDLE && start) begin
            i <= '0;
            j <= '0;
            k <= '0;
            m <= '0;
            n <= '0;
            l <= '0;
        end else if (enable && !last_term) begin
            i <= i_nx;
            j <= j_nx;
            k <= k_nx;
            m <= m_nx;
            n <= n_nx;
            l <= l_nx;
        end
    end

    // ------------------------------------------------------------------
    // Padding detection: tap position in the (unpadded) input image
    // ------------------------------------------------------------------
    assign row = 10'(STRIDE * int'(j) + int'(m) - PADDING);
    assign col = 10'(STRIDE * int'(k) + int'(n) - PADDING);
    assign out_of_image = (row < 10'sd0) || (row >= IMG_S) ||
                          (col < 10'sd0) || (col >= IMG_S);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pad_zero <= 1'b0;
        end else if (enable) begin
            pad_zero <= out_of_image;
        end
    end

    // ------------------------------------------------------------------
    // en_save delay line: shifts every cycle, regardless of stall
    // ------------------------------------------------------------------
    assign push = enable && pixel_last;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            save_dly <= '0;
        end else begin
            save_dly[0] <= push;
            for (int s = 1; s < SAVE_LAT; s++) begin
                save_dly[s] <= save_dly[s-1];
            end
        end
    end

    assign en_save = save_dly[SAVE_LAT-1];

endmodule
